// File: rtl/iram_ctrl_if.sv
// Bundles the core-facing miss/return signals and the memory request/grant/valid
// handshake of the instruction-RAM controller.
interface iram_ctrl_if #(
   parameter int PC_W       = 32,
   parameter int WORD_W     = 32,
   parameter int LINE_WORDS = 4
);
   localparam int OFF_W = $clog2(LINE_WORDS);

   logic              miss_cache;
   logic [PC_W-1:0]   ram_address;
   logic [WORD_W-1:0] mem_word;
   logic              word_ready;
   logic [OFF_W-1:0]  word_offs;
   logic              busy;
   logic              imem_req;
   logic [PC_W-1:0]   imem_addr;
   logic              imem_gnt;
   logic              imem_rvalid;
   logic [WORD_W-1:0] imem_rdata;

   // Environment side: the fetch unit plus the instruction memory.
   modport master (
      output miss_cache, ram_address, imem_gnt, imem_rvalid, imem_rdata,
      input  mem_word, word_ready, word_offs, busy, imem_req, imem_addr
   );

   // Controller side.
   modport slave (
      input  miss_cache, ram_address, imem_gnt, imem_rvalid, imem_rdata,
      output mem_word, word_ready, word_offs, busy, imem_req, imem_addr
   );
endinterface

// File: rtl/iram_ctrl.sv
// Instruction-cache line filler: fetches a whole line critical-word-first from a
// single-outstanding request/grant/valid memory and strobes each word to the core.
module iram_ctrl #(
   parameter int PC_W       = 32,
   parameter int WORD_W     = 32,
   parameter int LINE_WORDS = 4
) (
   input logic        clk,
   input logic        rst,
   iram_ctrl_if.slave bus
);
   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam logic [PC_W-1:0]  LINE_MASK = PC_W'(LINE_WORDS * 4 - 1);
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE
   } state_t;

   state_t            state_reg;
   logic [PC_W-1:0]   base_reg;
   logic [OFF_W-1:0]  offs_reg;
   logic [OFF_W-1:0]  cnt_reg;
   logic [WORD_W-1:0] mem_word_reg;
   logic              word_ready_reg;
   logic [OFF_W-1:0]  word_offs_reg;
   logic              busy_reg;
   logic              req_reg;
   logic [PC_W-1:0]   addr_reg;

   logic [PC_W-1:0]   line_base;
   logic [OFF_W-1:0]  start_offs;
   logic [OFF_W-1:0]  offs_next;

   assign line_base  = bus.ram_address & ~LINE_MASK;
   assign start_offs = bus.ram_address[OFF_W+1:2];
   // Natural OFF_W-bit overflow gives the in-line wrap; it never touches the base.
   assign offs_next  = offs_reg + OFF_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         base_reg       <= '0;
         offs_reg       <= '0;
         cnt_reg        <= '0;
         mem_word_reg   <= '0;
         word_ready_reg <= 1'b0;
         word_offs_reg  <= '0;
         busy_reg       <= 1'b0;
         req_reg        <= 1'b0;
         addr_reg       <= '0;
      end else begin
         word_ready_reg <= 1'b0;
         unique case (state_reg)
            S_IDLE: begin
               if (bus.miss_cache) begin
                  base_reg  <= line_base;
                  offs_reg  <= start_offs;
                  cnt_reg   <= '0;
                  req_reg   <= 1'b1;
                  addr_reg  <= line_base | PC_W'({start_offs, 2'b00});
                  busy_reg  <= 1'b1;
                  state_reg <= S_REQ;
               end
            end
            S_REQ: begin
               if (bus.imem_gnt) begin
                  req_reg   <= 1'b0;
                  state_reg <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.imem_rvalid) begin
                  mem_word_reg   <= bus.imem_rdata;
                  word_offs_reg  <= offs_reg;
                  word_ready_reg <= 1'b1;
                  offs_reg       <= offs_next;
                  cnt_reg        <= cnt_reg + OFF_W'(1);
                  if (cnt_reg == LAST_WORD) begin
                     state_reg <= S_DONE;
                  end else begin
                     // Next request goes out in the same cycle as this word's strobe.
                     req_reg   <= 1'b1;
                     addr_reg  <= base_reg | PC_W'({offs_next, 2'b00});
                     state_reg <= S_REQ;
                  end
               end
            end
            S_DONE: begin
               if (!bus.miss_cache) begin
                  busy_reg  <= 1'b0;
                  state_reg <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign bus.mem_word   = mem_word_reg;
   assign bus.word_ready = word_ready_reg;
   assign bus.word_offs  = word_offs_reg;
   assign bus.busy       = busy_reg;
   assign bus.imem_req   = req_reg;
   assign bus.imem_addr  = addr_reg;
endmodule

// File: tb/tb_iram_ctrl.sv
// Bench for iram_ctrl: a randomized-latency memory responder plus a line-fill
// reference model (critical word first, wrap inside the line) checks every burst.
module tb_iram_ctrl;
   localparam int PC_W   = 32;
   localparam int WORD_W = 32;
   localparam int LW     = 4;
   localparam int OFF_W  = $clog2(LW);

   typedef struct {
      logic [OFF_W-1:0]  offs;
      logic [WORD_W-1:0] data;
      time               t;
   } strobe_t;

   logic clk;
   logic rst;

   iram_ctrl_if #(.PC_W(PC_W), .WORD_W(WORD_W), .LINE_WORDS(LW)) bus ();

   iram_ctrl #(.PC_W(PC_W), .WORD_W(WORD_W), .LINE_WORDS(LW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int b2b_viol = 0;

   logic [PC_W-1:0] req_q[$];
   strobe_t         strb_q[$];

   // Memory responder knobs: delay ranges in cycles, and spurious rvalid while stalled in REQ.
   int gnt_lo = 0, gnt_hi = 0, rv_lo = 0, rv_hi = 0;
   bit spurious = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   function automatic logic [WORD_W-1:0] mem_val(input logic [PC_W-1:0] a);
      return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory responder: one outstanding request, gnt then rvalid in a later cycle.
   initial begin
      logic [PC_W-1:0] a;
      int n;
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      forever begin
         if (!(bus.imem_req === 1'b1 && rst === 1'b0)) begin
            @(negedge clk);
            continue;
         end
         a = bus.imem_addr;
         n = $urandom_range(gnt_hi, gnt_lo);
         for (int i = 0; i < n; i++) begin
            bus.imem_rvalid = spurious ? 1'($urandom_range(1, 0)) : 1'b0;
            bus.imem_rdata  = $urandom;
            @(negedge clk);
            check_eq("req_hold", bus.imem_req, 1);
            check_eq("addr_hold", bus.imem_addr, a);
         end
         bus.imem_rvalid = 1'b0;
         bus.imem_gnt    = 1'b1;
         req_q.push_back(a);
         @(negedge clk);
         bus.imem_gnt = 1'b0;
         n = $urandom_range(rv_hi, rv_lo);
         repeat (n) @(negedge clk);
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = mem_val(a);
         @(negedge clk);
         bus.imem_rvalid = 1'b0;
      end
   end

   // Strobe monitor, sampled on the falling edge.
   initial begin
      bit prev;
      strobe_t s;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.word_ready === 1'b1) begin
            s.offs = bus.word_offs;
            s.data = bus.mem_word;
            s.t    = $time;
            strb_q.push_back(s);
            if (prev) b2b_viol++;
         end
         prev = (bus.word_ready === 1'b1);
      end
   end

   // Called at negedge+1 with the controller idle; returns at negedge+1 with it idle again.
   task automatic do_miss(input logic [PC_W-1:0] addr, input bit drop_early, input bit check_time);
      time t0;
      int to;
      int o;
      logic [PC_W-1:0] ea;
      strb_q.delete();
      req_q.delete();
      bus.ram_address = addr;
      bus.miss_cache  = 1'b1;
      t0 = $time;
      @(negedge clk); #1;
      check_eq("busy_rise", bus.busy, 1);
      check_eq("req_rise", bus.imem_req, 1);
      bus.ram_address = $urandom;
      to = 0;
      while (strb_q.size() < LW && to < 1000) begin
         if (drop_early && strb_q.size() >= 1) bus.miss_cache = 1'b0;
         @(negedge clk); #1;
         to++;
      end
      check_eq("burst_in_time", (to < 1000), 1);
      bus.miss_cache = 1'b0;
      @(negedge clk); #1;
      check_eq("busy_fall", bus.busy, 0);
      check_eq("strobe_count", strb_q.size(), LW);
      check_eq("req_count", req_q.size(), LW);
      for (int i = 0; i < LW && i < strb_q.size() && i < req_q.size(); i++) begin
         o  = (int'(addr[OFF_W+1:2]) + i) % LW;
         ea = (addr & ~PC_W'(LW * 4 - 1)) + PC_W'(4 * o);
         check_eq("req_addr", req_q[i], ea);
         check_eq("word_offs", strb_q[i].offs, o);
         check_eq("mem_word", strb_q[i].data, mem_val(ea));
      end
      // Zero-wait memory: last strobe follows the accepting edge by 2*LW edges.
      if (check_time && strb_q.size() == LW)
         check_eq("latency", (strb_q[LW-1].t - t0) / 10, 2 * LW);
   endtask

   task automatic set_mem(input int glo, input int ghi, input int rlo, input int rhi, input bit sp);
      gnt_lo = glo; gnt_hi = ghi; rv_lo = rlo; rv_hi = rhi; spurious = sp;
   endtask

   initial begin
      int to;
      rst = 1'b1;
      bus.miss_cache  = 1'b0;
      bus.ram_address = '0;
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_busy", bus.busy, 0);
      check_eq("rst_req", bus.imem_req, 0);
      check_eq("rst_addr", bus.imem_addr, 0);
      check_eq("rst_ready", bus.word_ready, 0);
      check_eq("rst_word", bus.mem_word, 0);
      check_eq("rst_offs", bus.word_offs, 0);
      rst = 1'b0;
      @(negedge clk); #1;

      set_mem(0, 0, 0, 0, 0);
      do_miss(32'h0000_1000, 0, 1);
      do_miss(32'h0000_2008, 0, 1);

      set_mem(3, 3, 5, 5, 1);
      do_miss(32'h0000_2404, 0, 0);

      set_mem(0, 0, 0, 0, 0);
      do_miss(32'h0000_5004, 1, 0);
      do_miss(32'h0000_600C, 0, 1);

      // Asynchronous reset while waiting for read data.
      set_mem(0, 0, 5, 5, 0);
      strb_q.delete();
      req_q.delete();
      bus.ram_address = 32'h0000_3004;
      bus.miss_cache  = 1'b1;
      to = 0;
      while (req_q.size() == 0 && to < 100) begin
         @(negedge clk); #1;
         to++;
      end
      check_eq("rst_test_gnt", (to < 100), 1);
      @(negedge clk); #3;
      rst = 1'b1;
      bus.miss_cache = 1'b0;
      #1;
      check_eq("arst_busy", bus.busy, 0);
      check_eq("arst_req", bus.imem_req, 0);
      check_eq("arst_addr", bus.imem_addr, 0);
      check_eq("arst_ready", bus.word_ready, 0);
      check_eq("arst_word", bus.mem_word, 0);
      check_eq("arst_offs", bus.word_offs, 0);
      @(negedge clk); #1;
      rst = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      check_eq("late_rvalid_dropped", strb_q.size(), 0);
      check_eq("idle_after_rst", bus.busy, 0);

      set_mem(0, 0, 0, 0, 0);
      do_miss(32'h0000_300C, 0, 1);
      do_miss(32'hFFFF_FFFC, 0, 1);

      set_mem(0, 3, 0, 3, 1);
      for (int k = 0; k < 16; k++)
         do_miss($urandom, 1'($urandom_range(1, 0)), 0);

      check_eq("no_back_to_back", b2b_viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
